uart_tx_frame: RTL and testbench

Parametrised successor to the single-byte UART transmitter: serialises characters from an internal FIFO with configurable data width, runtime-selectable parity and one or two stop bits. Sits between the CPU-side peripheral register write strobe and the board TX pin. Frames are sent back-to-back with no idle gap while the FIFO holds data.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_frame_if.sv | 25 ++
 rtl/uart_fifo.sv | 56 +++++
 rtl/uart_tx_frame.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_frame.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity codes and counter sizing.
// Imported by both the TX framer and the planned RX block.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_e;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   // Width needed for a counter running 0..clks-1 (never narrower than one bit).
   function automatic int unsigned baud_cnt_width(input int unsigned clks);
      int unsigned w;
      w = $clog2(clks);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// CPU-side write port of the UART transmitter: character enqueue, frame
// configuration and FIFO status.
interface uart_tx_frame_if #(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned DEPTH     = 4
) ();

   logic [DATA_BITS-1:0]     i_char;
   logic                     i_write;
   logic [1:0]               i_parity;
   logic                     i_two_stop;
   logic                     o_full;
   logic [$clog2(DEPTH):0]   o_level;

   modport master (
      output i_char, i_write, i_parity, i_two_stop,
      input  o_full, o_level
   );

   modport slave (
      input  i_char, i_write, i_parity, i_two_stop,
      output o_full, o_level
   );

endinterface

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO; rdata always shows the head entry.
// Pushes while full and pops while empty are ignored.
module uart_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   // full is judged on the pre-edge count, so a push alongside a pop while full is still dropped
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign full  = (count == DEPTH[AW:0]);
   assign empty = (count == '0);
   assign level = count;

endmodule

// File: rtl/uart_tx_frame.sv
// FIFO-fed UART transmitter: start, DATA_BITS data bits LSB first, optional
// parity and one or two stop bits; frames run back-to-back while data is queued.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned DEPTH        = 4
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   uart_tx_frame_if.slave  bus,
   output logic            o_tx,
   output logic            o_busy
);

   localparam int unsigned CW = baud_cnt_width(CLKS_PER_BIT);
   localparam int unsigned BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   uart_state_e            state_q, state_d;
   logic [CW-1:0]          baud_q, baud_d;
   logic [BW-1:0]          bit_q, bit_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   par_q, par_d;
   logic                   tx_q, tx_d;
   logic [1:0]             cfg_par_q, cfg_par_d;
   logic                   cfg_two_q, cfg_two_d;

   logic                   pop;
   logic                   load;
   logic                   bit_end;
   logic                   par_en;
   logic [DATA_BITS-1:0]   fifo_rdata;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [$clog2(DEPTH):0] fifo_level;

   uart_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .push    (bus.i_write),
      .pop     (pop),
      .wdata   (bus.i_char),
      .rdata   (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   assign bus.o_full  = fifo_full;
   assign bus.o_level = fifo_level;
   assign o_tx        = tx_q;
   assign o_busy      = (state_q != IDLE) | ~fifo_empty;

   assign bit_end = (baud_q == BAUD_LAST);
   assign par_en  = (cfg_par_q == PAR_EVEN) || (cfg_par_q == PAR_ODD);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         baud_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         tx_q      <= 1'b1;
         cfg_par_q <= PAR_NONE;
         cfg_two_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         tx_q      <= tx_d;
         cfg_par_q <= cfg_par_d;
         cfg_two_q <= cfg_two_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      par_d     = par_q;
      tx_d      = tx_q;
      cfg_par_d = cfg_par_q;
      cfg_two_d = cfg_two_q;
      pop       = 1'b0;
      load      = 1'b0;

      if (state_q != IDLE) baud_d = bit_end ? '0 : baud_q + 1'b1;

      case (state_q)
         IDLE: begin
            if (!fifo_empty) load = 1'b1;
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               bit_d   = '0;
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
               par_d   = par_q ^ shift_q[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_q == BIT_LAST) begin
                  bit_d = '0;
                  if (par_en) begin
                     state_d = PARITY;
                     tx_d    = par_q ^ (cfg_par_q == PAR_ODD);
                  end else begin
                     state_d = STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d   = bit_q + 1'b1;
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
                  par_d   = par_q ^ shift_q[0];
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d = STOP;
               bit_d   = '0;
               tx_d    = 1'b1;
            end
         end
         STOP: begin
            // bit_q doubles as the stop-bit index here
            if (bit_end) begin
               if (cfg_two_q && (bit_q == '0)) begin
                  bit_d = BW'(1);
               end else if (!fifo_empty) begin
                  load = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase

      // Shared frame launch from IDLE and from the last stop bit (back-to-back)
      if (load) begin
         pop       = 1'b1;
         state_d   = START;
         baud_d    = '0;
         shift_d   = fifo_rdata;
         par_d     = 1'b0;
         tx_d      = 1'b0;
         cfg_par_d = bus.i_parity;
         cfg_two_d = bus.i_two_stop;
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: an 8-bit and a 5-bit instance checked
// every cycle against a queue model of the FIFO and the expected line waveform.
module tb_uart_tx_frame;

   localparam int unsigned C   = 4;
   localparam int unsigned DB  = 8;
   localparam int unsigned DB5 = 5;
   localparam int unsigned D   = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic tx_a, busy_a, tx_b, busy_b;

   int checks = 0;
   int errors = 0;

   // Model: pending characters and the per-cycle line values still to be sent.
   int mq_a[$];
   int mq_b[$];
   bit ln_a[$];
   bit ln_b[$];

   always #5 clk = ~clk;

   uart_tx_frame_if #(.DATA_BITS(DB),  .DEPTH(D)) bus_a ();
   uart_tx_frame_if #(.DATA_BITS(DB5), .DEPTH(D)) bus_b ();

   uart_tx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(DB), .DEPTH(D)) dut_a (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus_a),
      .o_tx    (tx_a),
      .o_busy  (busy_a)
   );

   uart_tx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(DB5), .DEPTH(D)) dut_b (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus_b),
      .o_tx    (tx_b),
      .o_busy  (busy_b)
   );

   task automatic add_frame(input int u, input int ch, input int nb,
                            input logic [1:0] par, input logic two);
      bit seq[$];
      int ones;
      ones = 0;
      seq.push_back(1'b0);
      for (int i = 0; i < nb; i++) begin
         seq.push_back(bit'((ch >> i) & 1));
         ones += (ch >> i) & 1;
      end
      if (par == 2'b01) seq.push_back(bit'(ones % 2));
      else if (par == 2'b10) seq.push_back(bit'((ones % 2) ^ 1));
      seq.push_back(1'b1);
      if (two) seq.push_back(1'b1);
      foreach (seq[i]) begin
         for (int k = 0; k < int'(C); k++) begin
            if (u == 0) ln_a.push_back(seq[i]);
            else        ln_b.push_back(seq[i]);
         end
      end
   endtask

   task automatic model_edge();
      int  pre;
      bit  acc;
      pre = mq_a.size();
      acc = (bus_a.i_write === 1'b1) && (pre < int'(D));
      if (ln_a.size() > 0) void'(ln_a.pop_front());
      if (ln_a.size() == 0 && pre > 0)
         add_frame(0, mq_a.pop_front(), DB, bus_a.i_parity, bus_a.i_two_stop);
      if (acc) mq_a.push_back(int'(bus_a.i_char));

      pre = mq_b.size();
      acc = (bus_b.i_write === 1'b1) && (pre < int'(D));
      if (ln_b.size() > 0) void'(ln_b.pop_front());
      if (ln_b.size() == 0 && pre > 0)
         add_frame(1, mq_b.pop_front(), DB5, bus_b.i_parity, bus_b.i_two_stop);
      if (acc) mq_b.push_back(int'(bus_b.i_char));
   endtask

   task automatic model_clear();
      mq_a.delete(); mq_b.delete(); ln_a.delete(); ln_b.delete();
   endtask

   // Expected {tx, busy, full, level}
   function automatic logic [5:0] exp_a();
      logic t;
      t = (ln_a.size() > 0) ? ln_a[0] : 1'b1;
      return {t, (ln_a.size() > 0 || mq_a.size() > 0), (mq_a.size() == int'(D)), 3'(mq_a.size())};
   endfunction

   function automatic logic [5:0] exp_b();
      logic t;
      t = (ln_b.size() > 0) ? ln_b[0] : 1'b1;
      return {t, (ln_b.size() > 0 || mq_b.size() > 0), (mq_b.size() == int'(D)), 3'(mq_b.size())};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      bus_a.i_char = '0; bus_a.i_write = 1'b0; bus_a.i_parity = 2'b00; bus_a.i_two_stop = 1'b0;
      bus_b.i_char = '0; bus_b.i_write = 1'b0; bus_b.i_parity = 2'b00; bus_b.i_two_stop = 1'b0;
      rst_n = 1'b0;
      model_clear();
      repeat (3) @(negedge clk);
      checks++;
      if ({tx_a, busy_a, bus_a.o_full, bus_a.o_level} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_a got %b exp %b (tx,busy,full,level)", {tx_a, busy_a, bus_a.o_full, bus_a.o_level}, 6'b100000);
      end
      checks++;
      if ({tx_b, busy_b, bus_b.o_full, bus_b.o_level} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_b got %b exp %b (tx,busy,full,level)", {tx_b, busy_b, bus_b.o_full, bus_b.o_level}, 6'b100000);
      end
      rst_n = 1'b1;
      repeat (3) begin
         tick();
         checks++;
         if ({tx_a, busy_a, bus_a.o_full, bus_a.o_level} !== exp_a()) begin
            errors++;
            $display("FAIL reset_idle t=%0t got %b exp %b", $time, {tx_a, busy_a, bus_a.o_full, bus_a.o_level}, exp_a());
         end
      end
   endtask

   task automatic test_single();
      bus_a.i_parity = 2'b00; bus_a.i_two_stop = 1'b0;
      bus_a.i_char = 8'h55; bus_a.i_write = 1'b1;
      tick();
      bus_a.i_write = 1'b0;
      checks++;
      if ({tx_a, busy_a, bus_a.o_level} !== 5'b11001) begin
         errors++;
         $display("FAIL single_accept got %b exp %b (tx,busy,level)", {tx_a, busy_a, bus_a.o_level}, 5'b11001);
      end
      tick();
      checks++;
      if (tx_a !== 1'b0) begin
         errors++;
         $display("FAIL single_start_latency got %b exp 0", tx_a);
      end
      repeat (40) begin
         tick();
         checks++;
         if ({tx_a, busy_a, bus_a.o_full, bus_a.o_level} !== exp_a()) begin
            errors++;
            $display("FAIL single t=%0t got %b exp %b", $time, {tx_a, busy_a, bus_a.o_full, bus_a.o_level}, exp_a());
         end
      end
      checks++;
      if ({tx_a, busy_a} !== 2'b10) begin
         errors++;
         $display("FAIL single_end got %b exp 10 (tx,busy)", {tx_a, busy_a});
      end
   endtask

   task automatic test_parity();
      logic [7:0]  chars [3];
      logic [1:0]  pars  [3];
      chars = '{8'h07, 8'h07, 8'h03};
      pars  = '{2'b01, 2'b10, 2'b10};
      bus_a.i_two_stop = 1'b0;
      for (int f = 0; f < 3; f++) begin
         bus_a.i_parity = pars[f];
         bus_a.i_char   = chars[f];
         bus_a.i_write  = 1'b1;
         tick();
         bus_a.i_write  = 1'b0;
         repeat (47) begin
            tick();
            checks++;
            if ({tx_a, busy_a, bus_a.o_full, bus_a.o_level} !== exp_a()) begin
               errors++;
               $display("FAIL parity%0d t=%0t got %b exp %b", f, $time, {tx_a, busy_a, bus_a.o_full, bus_a.o_level}, exp_a());
            end
         end
      end
      bus_a.i_parity = 2'b00;
   endtask

   task automatic test_two_stop();
      bus_a.i_parity = 2'b00; bus_a.i_two_stop = 1'b1;
      bus_a.i_char = 8'hA0; bus_a.i_write = 1'b1;
      tick();
      bus_a.i_write = 1'b0;
      tick();
      bus_a.i_two_stop = 1'b0;
      repeat (48) begin
         tick();
         checks++;
         if ({tx_a, busy_a, bus_a.o_full, bus_a.o_level} !== exp_a()) begin
            errors++;
            $display("FAIL two_stop t=%0t got %b exp %b", $time, {tx_a, busy_a, bus_a.o_full, bus_a.o_level}, exp_a());
         end
      end
   endtask

   task automatic test_back_to_back();
      bus_a.i_parity = 2'b00; bus_a.i_two_stop = 1'b0;
      for (int w = 0; w < 6; w++) begin
         bus_a.i_char  = 8'($urandom);
         bus_a.i_write = 1'b1;
         tick();
         checks++;
         if ({tx_a, busy_a, bus_a.o_full, bus_a.o_level} !== exp_a()) begin
            errors++;
            $display("FAIL burst_write%0d got %b exp %b", w, {tx_a, busy_a, bus_a.o_full, bus_a.o_level}, exp_a());
         end
         if (w >= 4) begin
            checks++;
            if ({bus_a.o_full, bus_a.o_level} !== 4'b1100) begin
               errors++;
               $display("FAIL burst_full%0d got %b exp 1100 (full,level)", w, {bus_a.o_full, bus_a.o_level});
            end
         end
      end
      bus_a.i_write = 1'b0;
      repeat (210) begin
         tick();
         checks++;
         if ({tx_a, busy_a, bus_a.o_full, bus_a.o_level} !== exp_a()) begin
            errors++;
            $display("FAIL burst t=%0t got %b exp %b", $time, {tx_a, busy_a, bus_a.o_full, bus_a.o_level}, exp_a());
         end
      end
   endtask

   task automatic test_narrow();
      bus_b.i_parity = 2'b00; bus_b.i_two_stop = 1'b0;
      bus_b.i_char = 5'h1F; bus_b.i_write = 1'b1;
      tick();
      bus_b.i_write = 1'b0;
      repeat (31) begin
         tick();
         checks++;
         if ({tx_b, busy_b, bus_b.o_full, bus_b.o_level} !== exp_b()) begin
            errors++;
            $display("FAIL narrow t=%0t got %b exp %b", $time, {tx_b, busy_b, bus_b.o_full, bus_b.o_level}, exp_b());
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 10; n++) begin
         bus_a.i_parity   = 2'($urandom_range(0, 3));
         bus_a.i_two_stop = 1'($urandom_range(0, 1));
         bus_a.i_char     = 8'($urandom);
         bus_a.i_write    = 1'b1;
         tick();
         bus_a.i_write    = 1'b0;
         repeat ($urandom_range(0, 60)) begin
            tick();
            checks++;
            if ({tx_a, busy_a, bus_a.o_full, bus_a.o_level} !== exp_a()) begin
               errors++;
               $display("FAIL random t=%0t got %b exp %b", $time, {tx_a, busy_a, bus_a.o_full, bus_a.o_level}, exp_a());
            end
         end
      end
      repeat (300) begin
         tick();
         checks++;
         if ({tx_a, busy_a, bus_a.o_full, bus_a.o_level} !== exp_a()) begin
            errors++;
            $display("FAIL random_drain t=%0t got %b exp %b", $time, {tx_a, busy_a, bus_a.o_full, bus_a.o_level}, exp_a());
         end
      end
   endtask

   task automatic test_reset_mid();
      bus_a.i_parity = 2'b00; bus_a.i_two_stop = 1'b0;
      for (int w = 0; w < 2; w++) begin
         bus_a.i_char  = 8'($urandom);
         bus_a.i_write = 1'b1;
         tick();
      end
      bus_a.i_write = 1'b0;
      repeat (14) begin
         tick();
         checks++;
         if ({tx_a, busy_a, bus_a.o_full, bus_a.o_level} !== exp_a()) begin
            errors++;
            $display("FAIL reset_mid_pre t=%0t got %b exp %b", $time, {tx_a, busy_a, bus_a.o_full, bus_a.o_level}, exp_a());
         end
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({tx_a, busy_a, bus_a.o_level} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_async got %b exp 10000 (tx,busy,level)", {tx_a, busy_a, bus_a.o_level});
      end
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) begin
         tick();
         checks++;
         if ({tx_a, busy_a, bus_a.o_full, bus_a.o_level} !== exp_a()) begin
            errors++;
            $display("FAIL reset_mid_post t=%0t got %b exp %b", $time, {tx_a, busy_a, bus_a.o_full, bus_a.o_level}, exp_a());
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_parity();
      test_two_stop();
      test_back_to_back();
      test_narrow();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
